// File: rtl/cond_exec_unit_if.sv
// Decode-to-execute control bundle for cond_exec_unit.
// No latency of its own; carries decoded controls in and registered/gated controls out.
// StallE/FlushE are the only flow control; there is no valid/ready handshake.
interface cond_exec_unit_if #(
  parameter int ALUCTRL_W = 3
);
  logic                 StallE;
  logic                 FlushE;
  logic [3:0]           CondD;
  logic                 PCSrcD;
  logic                 RegWriteD;
  logic                 MemWriteD;
  logic                 MemtoRegD;
  logic                 ALUSrcD;
  logic                 BranchD;
  logic [1:0]           FlagWriteD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic [3:0]           ALUFlags;

  logic [ALUCTRL_W-1:0] ALUControlE;
  logic                 ALUSrcE;
  logic                 CondExE;
  logic                 BranchTakenE;
  logic                 PCSrcM;
  logic                 RegWriteM;
  logic                 MemWriteM;
  logic                 MemtoRegM;
  logic [3:0]           FlagsQ;

  // Execute-stage consumer side.
  modport slave (
    input  StallE, FlushE, CondD, PCSrcD, RegWriteD, MemWriteD, MemtoRegD,
           ALUSrcD, BranchD, FlagWriteD, ALUControlD, ALUFlags,
    output ALUControlE, ALUSrcE, CondExE, BranchTakenE, PCSrcM, RegWriteM,
           MemWriteM, MemtoRegM, FlagsQ
  );

  // Decode controller / datapath side.
  modport master (
    output StallE, FlushE, CondD, PCSrcD, RegWriteD, MemWriteD, MemtoRegD,
           ALUSrcD, BranchD, FlagWriteD, ALUControlD, ALUFlags,
    input  ALUControlE, ALUSrcE, CondExE, BranchTakenE, PCSrcM, RegWriteM,
           MemWriteM, MemtoRegM, FlagsQ
  );
endinterface

// File: rtl/cond_exec_unit.sv
// Execute-stage conditional execution: D->E control register, NZCV flags, condition gating into M.
// Latency: D inputs to E outputs 1 cycle, to M outputs 2 cycles; CondExE/BranchTakenE combinational.
// Backpressure: StallE holds E, blocks flag writes and feeds M bubbles; FlushE bubbles E and beats StallE.
module cond_exec_unit #(
  parameter int ALUCTRL_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  cond_exec_unit_if.slave bus
);

  typedef struct packed {
    logic [3:0]           cond;
    logic                 pcSrc;
    logic                 regWrite;
    logic                 memWrite;
    logic                 memtoReg;
    logic                 aluSrc;
    logic                 branch;
    logic [1:0]           flagWrite;
    logic [ALUCTRL_W-1:0] aluControl;
  } ctrl_t;

  localparam logic [3:0] COND_AL = 4'b1110;

  ctrl_t      ctrlD;
  ctrl_t      ctrlE;
  ctrl_t      bubble;
  logic [3:0] flagsQ;
  logic       condEx;
  logic       flagN, flagZ, flagC, flagV;
  logic       pcSrcM, regWriteM, memWriteM, memtoRegM;

  assign {flagN, flagZ, flagC, flagV} = flagsQ;

  // Pack the decode-stage inputs and the flush bubble (AL, all enables off).
  always_comb begin
    ctrlD            = '0;
    ctrlD.cond       = bus.CondD;
    ctrlD.pcSrc      = bus.PCSrcD;
    ctrlD.regWrite   = bus.RegWriteD;
    ctrlD.memWrite   = bus.MemWriteD;
    ctrlD.memtoReg   = bus.MemtoRegD;
    ctrlD.aluSrc     = bus.ALUSrcD;
    ctrlD.branch     = bus.BranchD;
    ctrlD.flagWrite  = bus.FlagWriteD;
    ctrlD.aluControl = bus.ALUControlD;
    bubble           = '0;
    bubble.cond      = COND_AL;
  end

  // E register: reset, then flush, then stall-hold, else load from decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrlE <= '0;
    end else if (bus.FlushE) begin
      ctrlE <= bubble;
    end else if (!bus.StallE) begin
      ctrlE <= ctrlD;
    end
  end

  // ARM condition field evaluated against the architectural flags; 1111 squashes.
  always_comb begin
    condEx = 1'b0;
    case (ctrlE.cond)
      4'b0000: condEx = flagZ;
      4'b0001: condEx = ~flagZ;
      4'b0010: condEx = flagC;
      4'b0011: condEx = ~flagC;
      4'b0100: condEx = flagN;
      4'b0101: condEx = ~flagN;
      4'b0110: condEx = flagV;
      4'b0111: condEx = ~flagV;
      4'b1000: condEx = flagC & ~flagZ;
      4'b1001: condEx = ~flagC | flagZ;
      4'b1010: condEx = (flagN == flagV);
      4'b1011: condEx = (flagN != flagV);
      4'b1100: condEx = ~flagZ & (flagN == flagV);
      4'b1101: condEx = flagZ | (flagN != flagV);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  // Flags update only when the instruction in E retires this edge (not stalled) and passes.
  // A flush does not block this: it only replaces the incoming instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flagsQ <= 4'b0000;
    end else if (!bus.StallE) begin
      if (ctrlE.flagWrite[1] && condEx) flagsQ[3:2] <= bus.ALUFlags[3:2];
      if (ctrlE.flagWrite[0] && condEx) flagsQ[1:0] <= bus.ALUFlags[1:0];
    end
  end

  // M register: gated enables; a stalled E sends bubbles so it commits exactly once.
  always_ff @(posedge clk) begin
    if (!reset || bus.StallE) begin
      pcSrcM    <= 1'b0;
      regWriteM <= 1'b0;
      memWriteM <= 1'b0;
      memtoRegM <= 1'b0;
    end else begin
      pcSrcM    <= ctrlE.pcSrc & condEx;
      regWriteM <= ctrlE.regWrite & condEx;
      memWriteM <= ctrlE.memWrite & condEx;
      memtoRegM <= ctrlE.memtoReg;
    end
  end

  assign bus.ALUControlE  = ctrlE.aluControl;
  assign bus.ALUSrcE      = ctrlE.aluSrc;
  assign bus.CondExE      = condEx;
  assign bus.BranchTakenE = ctrlE.branch & condEx;
  assign bus.PCSrcM       = pcSrcM;
  assign bus.RegWriteM    = regWriteM;
  assign bus.MemWriteM    = memWriteM;
  assign bus.MemtoRegM    = memtoRegM;
  assign bus.FlagsQ       = flagsQ;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Self-checking bench for cond_exec_unit: directed scenarios plus randomized traffic.
// Reference model tracks the instruction in E, the M enables and the flags at instruction level.
// Stall/flush/reset are driven randomly in the random phase.
module tb_cond_exec_unit;
  localparam int AW = 3;

  typedef struct packed {
    logic [3:0]    cond;
    logic          pcSrc;
    logic          regWrite;
    logic          memWrite;
    logic          memtoReg;
    logic          aluSrc;
    logic          branch;
    logic [1:0]    flagWrite;
    logic [AW-1:0] aluCtl;
  } instr_t;

  logic clk = 1'b0;
  logic reset;

  cond_exec_unit_if #(.ALUCTRL_W(AW)) bus ();

  cond_exec_unit #(.ALUCTRL_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state.
  instr_t     mE     = '0;
  logic [3:0] mFlags = 4'b0000;
  logic       mPcM   = 1'b0;
  logic       mRegM  = 1'b0;
  logic       mMemM  = 1'b0;
  logic       mMtrM  = 1'b0;

  task automatic checkEq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Architectural rule: even codes test a base predicate, odd codes its inverse; 1110 always, 1111 never.
  function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b0;
    endcase
    return base ^ c[0];
  endfunction

  function automatic instr_t nopI();
    instr_t i;
    i      = '0;
    i.cond = 4'hE;
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    i = instr_t'($urandom);
    return i;
  endfunction

  function automatic instr_t readD();
    instr_t i;
    i.cond      = bus.CondD;
    i.pcSrc     = bus.PCSrcD;
    i.regWrite  = bus.RegWriteD;
    i.memWrite  = bus.MemWriteD;
    i.memtoReg  = bus.MemtoRegD;
    i.aluSrc    = bus.ALUSrcD;
    i.branch    = bus.BranchD;
    i.flagWrite = bus.FlagWriteD;
    i.aluCtl    = bus.ALUControlD;
    return i;
  endfunction

  task automatic drive(input instr_t i, input logic st, input logic fl, input logic [3:0] af);
    bus.CondD       = i.cond;
    bus.PCSrcD      = i.pcSrc;
    bus.RegWriteD   = i.regWrite;
    bus.MemWriteD   = i.memWrite;
    bus.MemtoRegD   = i.memtoReg;
    bus.ALUSrcD     = i.aluSrc;
    bus.BranchD     = i.branch;
    bus.FlagWriteD  = i.flagWrite;
    bus.ALUControlD = i.aluCtl;
    bus.StallE      = st;
    bus.FlushE      = fl;
    bus.ALUFlags    = af;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare every output.
  task automatic cycle(input string tag);
    logic       ok;
    logic [3:0] nf;
    instr_t     b;
    @(posedge clk);
    ok = condPass(mE.cond, mFlags);
    if (!reset) begin
      mE     = '0;
      mFlags = 4'b0000;
      {mPcM, mRegM, mMemM, mMtrM} = 4'b0000;
    end else begin
      nf = mFlags;
      if (!bus.StallE && ok) begin
        if (mE.flagWrite[1]) nf[3:2] = bus.ALUFlags[3:2];
        if (mE.flagWrite[0]) nf[1:0] = bus.ALUFlags[1:0];
      end
      if (bus.StallE) begin
        {mPcM, mRegM, mMemM, mMtrM} = 4'b0000;
      end else begin
        mPcM  = mE.pcSrc && ok;
        mRegM = mE.regWrite && ok;
        mMemM = mE.memWrite && ok;
        mMtrM = mE.memtoReg;
      end
      b = nopI();
      if (bus.FlushE)      mE = b;
      else if (!bus.StallE) mE = readD();
      mFlags = nf;
    end
    #1;
    ok = condPass(mE.cond, mFlags);
    checkEq({tag, ".ALUControlE"},  4'(bus.ALUControlE),  4'(mE.aluCtl));
    checkEq({tag, ".ALUSrcE"},      4'(bus.ALUSrcE),      4'(mE.aluSrc));
    checkEq({tag, ".CondExE"},      4'(bus.CondExE),      4'(ok));
    checkEq({tag, ".BranchTakenE"}, 4'(bus.BranchTakenE), 4'(mE.branch && ok));
    checkEq({tag, ".PCSrcM"},       4'(bus.PCSrcM),       4'(mPcM));
    checkEq({tag, ".RegWriteM"},    4'(bus.RegWriteM),    4'(mRegM));
    checkEq({tag, ".MemWriteM"},    4'(bus.MemWriteM),    4'(mMemM));
    checkEq({tag, ".MemtoRegM"},    4'(bus.MemtoRegM),    4'(mMtrM));
    checkEq({tag, ".FlagsQ"},       bus.FlagsQ,           mFlags);
  endtask

  // CMP-style setter into E, then write f on the following edge; leaves a NOP in E.
  task automatic loadFlags(input logic [3:0] f);
    instr_t s;
    s           = nopI();
    s.flagWrite = 2'b11;
    drive(s, 1'b0, 1'b0, 4'($urandom));
    cycle("ldf.e");
    drive(nopI(), 1'b0, 1'b0, f);
    cycle("ldf.w");
    checkEq("ldf.FlagsQ", bus.FlagsQ, f);
  endtask

  initial begin
    instr_t i;

    // Reset held two cycles with arbitrary inputs.
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(randInstr(), 1'($urandom), 1'($urandom), 4'($urandom));
      cycle("rst");
    end
    checkEq("rst.FlagsQ",      bus.FlagsQ,          4'b0000);
    checkEq("rst.RegWriteM",   4'(bus.RegWriteM),   4'b0000);
    checkEq("rst.MemWriteM",   4'(bus.MemWriteM),   4'b0000);
    checkEq("rst.PCSrcM",      4'(bus.PCSrcM),      4'b0000);
    checkEq("rst.ALUControlE", 4'(bus.ALUControlE), 4'b0000);
    reset = 1'b1;

    // ADDS writes all flags, ANDS-style writes only N,Z.
    i = nopI(); i.flagWrite = 2'b11; i.regWrite = 1'b1;
    drive(i, 1'b0, 1'b0, 4'($urandom));
    cycle("adds.e");
    i = nopI(); i.flagWrite = 2'b10; i.regWrite = 1'b1;
    drive(i, 1'b0, 1'b0, 4'b0110);
    cycle("adds.w");
    checkEq("adds.FlagsQ", bus.FlagsQ, 4'b0110);
    drive(nopI(), 1'b0, 1'b0, 4'b1001);
    cycle("ands.w");
    checkEq("ands.FlagsQ", bus.FlagsQ, 4'b1010);

    // Full condition table: every code against every flag value.
    for (int f = 0; f < 16; f++) begin
      loadFlags(4'(f));
      for (int c = 0; c < 16; c++) begin
        i = randInstr(); i.cond = 4'(c); i.flagWrite = 2'b00;
        drive(i, 1'b0, 1'b0, 4'($urandom));
        cycle("cond");
        if (f == 5 && c == 12) checkEq("cond.GT_Z1V1", 4'(bus.CondExE), 4'b0000);
        if (f == 5 && c == 13) checkEq("cond.LE_Z1V1", 4'(bus.CondExE), 4'b0001);
      end
    end

    // Squashed STR (EQ with Z=0) must neither store nor write flags.
    loadFlags(4'b0000);
    i = nopI(); i.cond = 4'b0000; i.memWrite = 1'b1; i.flagWrite = 2'b11;
    drive(i, 1'b0, 1'b0, 4'($urandom));
    cycle("str0.e");
    drive(nopI(), 1'b0, 1'b0, 4'b1111);
    cycle("str0.m");
    checkEq("squash.MemWriteM", 4'(bus.MemWriteM), 4'b0000);
    checkEq("squash.FlagsQ",    bus.FlagsQ,        4'b0000);
    loadFlags(4'b0100);
    i = nopI(); i.cond = 4'b0000; i.memWrite = 1'b1;
    drive(i, 1'b0, 1'b0, 4'($urandom));
    cycle("str1.e");
    drive(nopI(), 1'b0, 1'b0, 4'($urandom));
    cycle("str1.m");
    checkEq("pass.MemWriteM", 4'(bus.MemWriteM), 4'b0001);

    // BNE taken with Z=0, not taken with Z=1.
    for (int z = 0; z < 2; z++) begin
      loadFlags(z == 1 ? 4'b0100 : 4'b0000);
      i = nopI(); i.cond = 4'b0001; i.branch = 1'b1; i.pcSrc = 1'b1;
      drive(i, 1'b0, 1'b0, 4'($urandom));
      cycle("bne.e");
      checkEq("bne.BranchTakenE", 4'(bus.BranchTakenE), (z == 1) ? 4'b0000 : 4'b0001);
      drive(nopI(), 1'b0, 1'b0, 4'($urandom));
      cycle("bne.m");
      checkEq("bne.PCSrcM", 4'(bus.PCSrcM), (z == 1) ? 4'b0000 : 4'b0001);
    end

    // SUBS stalled two cycles: E held, M bubbles, flags written once on release.
    loadFlags(4'b0000);
    i = nopI(); i.flagWrite = 2'b11; i.regWrite = 1'b1; i.aluCtl = 3'b001;
    drive(i, 1'b0, 1'b0, 4'($urandom));
    cycle("subs.e");
    for (int k = 0; k < 2; k++) begin
      drive(randInstr(), 1'b1, 1'b0, 4'b1000);
      cycle("subs.st");
      checkEq("stall.ALUControlE", 4'(bus.ALUControlE), 4'b0001);
      checkEq("stall.RegWriteM",   4'(bus.RegWriteM),   4'b0000);
      checkEq("stall.FlagsQ",      bus.FlagsQ,          4'b0000);
    end
    drive(nopI(), 1'b0, 1'b0, 4'b1000);
    cycle("subs.rel");
    checkEq("release.FlagsQ",    bus.FlagsQ,        4'b1000);
    checkEq("release.RegWriteM", 4'(bus.RegWriteM), 4'b0001);
    drive(nopI(), 1'b0, 1'b0, 4'b0111);
    cycle("subs.after");
    checkEq("once.FlagsQ", bus.FlagsQ, 4'b1000);

    // Flush beats stall: E becomes an AL bubble.
    i = nopI(); i.regWrite = 1'b1; i.aluCtl = 3'b101; i.aluSrc = 1'b1;
    drive(i, 1'b0, 1'b0, 4'($urandom));
    cycle("fs.e");
    drive(randInstr(), 1'b1, 1'b1, 4'($urandom));
    cycle("fs.fl");
    checkEq("flushstall.CondExE",     4'(bus.CondExE),     4'b0001);
    checkEq("flushstall.ALUControlE", 4'(bus.ALUControlE), 4'b0000);
    checkEq("flushstall.ALUSrcE",     4'(bus.ALUSrcE),     4'b0000);
    drive(nopI(), 1'b0, 1'b0, 4'($urandom));
    cycle("fs.m");
    checkEq("flushstall.RegWriteM", 4'(bus.RegWriteM), 4'b0000);

    // Flush alongside a flag-setting instruction in E: its flag write still commits.
    loadFlags(4'b0000);
    i = nopI(); i.flagWrite = 2'b11;
    drive(i, 1'b0, 1'b0, 4'($urandom));
    cycle("ff.e");
    drive(randInstr(), 1'b0, 1'b1, 4'b0011);
    cycle("ff.w");
    checkEq("flushflag.FlagsQ", bus.FlagsQ, 4'b0011);

    // Random traffic with occasional stall, flush and reset.
    for (int n = 0; n < 3000; n++) begin
      drive(randInstr(), ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0), 4'($urandom));
      reset = ($urandom_range(63, 0) != 0);
      cycle("rnd");
    end
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
